// File: rtl/sdram_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_cmd_arbiter_if
//
// Bundles everything that crosses the boundary of sdram_cmd_arbiter apart
// from clock and reset: the two requester handshakes, the shared SDRAM
// command port, and the status flags.
//
// Modports
//   master : the arbiter itself. It receives the requests, the init flag and
//            CMD_ACK, and drives the grants, dones, CMD/ADDR and status.
//   slave  : the surrounding logic, i.e. both requesters plus the SDRAM
//            command interface (or a testbench standing in for them).
//
// Signals
//   INIT_DONE          SDRAM initialisation complete (level)
//   WR_REQ / WR_ADDR   write requester request (level) and burst address
//   WR_GNT / WR_DONE   write grant pulse, end-of-write-window pulse
//   RD_REQ / RD_ADDR   read requester request (level) and burst address
//   RD_GNT / RD_DONE   read grant pulse, end-of-read-window pulse
//   CMD / ADDR         command (00 NOP, 01 READA, 10 WRITEA) and address
//   CMD_ACK            one-cycle acknowledge from the command interface
//   BUSY               high whenever the arbiter is not idle in ARB
//   ACK_ERR            one-cycle pulse when an acknowledge never arrived
// ---------------------------------------------------------------------------
interface sdram_cmd_arbiter_if #(
    parameter int ASIZE = 22
);
    logic             INIT_DONE;
    logic             WR_REQ;
    logic [ASIZE-1:0] WR_ADDR;
    logic             WR_GNT;
    logic             WR_DONE;
    logic             RD_REQ;
    logic [ASIZE-1:0] RD_ADDR;
    logic             RD_GNT;
    logic             RD_DONE;
    logic [1:0]       CMD;
    logic [ASIZE-1:0] ADDR;
    logic             CMD_ACK;
    logic             BUSY;
    logic             ACK_ERR;

    modport master (
        input  INIT_DONE,
        input  WR_REQ,
        input  WR_ADDR,
        input  RD_REQ,
        input  RD_ADDR,
        input  CMD_ACK,
        output WR_GNT,
        output WR_DONE,
        output RD_GNT,
        output RD_DONE,
        output CMD,
        output ADDR,
        output BUSY,
        output ACK_ERR
    );

    modport slave (
        output INIT_DONE,
        output WR_REQ,
        output WR_ADDR,
        output RD_REQ,
        output RD_ADDR,
        output CMD_ACK,
        input  WR_GNT,
        input  WR_DONE,
        input  RD_GNT,
        input  RD_DONE,
        input  CMD,
        input  ADDR,
        input  BUSY,
        input  ACK_ERR
    );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_cmd_arbiter
//
// Shares the single SDRAM CMD/ADDR/CMD_ACK command port between a write
// requester (UART RX side) and a read requester (UART TX side). Nothing is
// issued until SDRAM initialisation has completed. After that the block issues
// one WRITEA/READA at a time, keeps the port owned for a fixed data window
// after the acknowledge, and gives up on a command whose acknowledge never
// arrives.
//
// Parameters
//   ASIZE        address width
//   DATA_CYC     cycles the port stays owned after CMD_ACK (1..255)
//   ACK_TIMEOUT  cycles spent waiting for CMD_ACK before aborting (2..255)
//
// Ports
//   CLK      system clock, shared with the SDRAM command interface
//   RESET_N  asynchronous active-low reset
//   bus      sdram_cmd_arbiter_if.master carrying requests, grants, dones,
//            the command port and the BUSY/ACK_ERR status flags
//
// Every output comes straight from a flop. The next-state logic computes the
// next value of each output alongside the next state, so outputs line up with
// the state they describe.
// ---------------------------------------------------------------------------
module sdram_cmd_arbiter #(
    parameter int ASIZE       = 22,
    parameter int DATA_CYC    = 12,
    parameter int ACK_TIMEOUT = 64
) (
    input logic                 CLK,
    input logic                 RESET_N,
    sdram_cmd_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_ARB       = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_DATA      = 2'd3
    } state_t;

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_READA  = 2'b01;
    localparam logic [1:0] CMD_WRITEA = 2'b10;

    // Counter reload value and abort threshold, both 8 bits wide.
    localparam logic [7:0] DATA_LOAD = 8'(DATA_CYC - 1);
    localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic             wr_gnt_q, wr_gnt_d;
    logic             rd_gnt_q, rd_gnt_d;
    logic             wr_done_q, wr_done_d;
    logic             rd_done_q, rd_done_d;
    logic             ack_err_q, ack_err_d;
    logic             busy_q, busy_d;
    // Port ids are encoded as 1 = read, 0 = write.
    logic             port_rd_q, port_rd_d;
    logic             last_rd_q, last_rd_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic [7:0]       data_cnt_q, data_cnt_d;
    logic             grant_rd;
    logic             done_d;

    // State register. Reset always returns to WAIT_INIT, so any in-flight
    // burst is abandoned and the init handshake is repeated.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_WAIT_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs and datapath. The last-served flag resets to
    // "read" so that the write requester wins the first tie.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd_q      <= CMD_NOP;
            addr_q     <= '0;
            wr_gnt_q   <= 1'b0;
            rd_gnt_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            ack_err_q  <= 1'b0;
            busy_q     <= 1'b1;
            port_rd_q  <= 1'b0;
            last_rd_q  <= 1'b1;
            tmo_cnt_q  <= '0;
            data_cnt_q <= '0;
        end else begin
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            ack_err_q  <= ack_err_d;
            busy_q     <= busy_d;
            port_rd_q  <= port_rd_d;
            last_rd_q  <= last_rd_d;
            tmo_cnt_q  <= tmo_cnt_d;
            data_cnt_q <= data_cnt_d;
        end
    end

    // Next-state and next-output logic. Requests are only looked at in ARB;
    // CMD_ACK is only looked at in ISSUE. Grants, DONE and ACK_ERR default
    // to zero, which keeps them as single-cycle pulses.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wr_gnt_d   = 1'b0;
        rd_gnt_d   = 1'b0;
        ack_err_d  = 1'b0;
        port_rd_d  = port_rd_q;
        last_rd_d  = last_rd_q;
        tmo_cnt_d  = tmo_cnt_q;
        data_cnt_d = data_cnt_q;
        grant_rd   = 1'b0;

        case (state_q)
            ST_WAIT_INIT: begin
                cmd_d = CMD_NOP;
                if (bus.INIT_DONE) begin
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                cmd_d = CMD_NOP;
                if (bus.WR_REQ || bus.RD_REQ) begin
                    // Read wins when it is alone, or when both are asking
                    // and write was the last port served.
                    grant_rd  = bus.RD_REQ && (!bus.WR_REQ || !last_rd_q);
                    state_d   = ST_ISSUE;
                    port_rd_d = grant_rd;
                    tmo_cnt_d = '0;
                    if (grant_rd) begin
                        rd_gnt_d = 1'b1;
                        cmd_d    = CMD_READA;
                        addr_d   = bus.RD_ADDR;
                    end else begin
                        wr_gnt_d = 1'b1;
                        cmd_d    = CMD_WRITEA;
                        addr_d   = bus.WR_ADDR;
                    end
                end
            end

            ST_ISSUE: begin
                // CMD/ADDR hold their values until the command is accepted
                // or abandoned. An acknowledge that lands on the very cycle
                // the timeout would fire still counts as accepted.
                if (bus.CMD_ACK) begin
                    state_d    = ST_DATA;
                    cmd_d      = CMD_NOP;
                    last_rd_d  = port_rd_q;
                    data_cnt_d = DATA_LOAD;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Abandoned commands still flip the round-robin flag so a
                    // port whose commands never get acknowledged cannot keep
                    // the other port starved.
                    state_d   = ST_ARB;
                    cmd_d     = CMD_NOP;
                    ack_err_d = 1'b1;
                    last_rd_d = port_rd_q;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end

            ST_DATA: begin
                cmd_d = CMD_NOP;
                if (data_cnt_q == '0) begin
                    state_d = ST_ARB;
                end else begin
                    data_cnt_d = data_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_WAIT_INIT;
                cmd_d   = CMD_NOP;
            end
        endcase

        // DONE is registered, so it is raised when the next cycle is the
        // DATA cycle whose count is zero. This also covers DATA_CYC = 1,
        // where that cycle is the first one after the acknowledge.
        done_d    = (state_d == ST_DATA) && (data_cnt_d == '0);
        wr_done_d = done_d && !port_rd_d;
        rd_done_d = done_d && port_rd_d;
        busy_d    = (state_d != ST_ARB);
    end

    assign bus.CMD     = cmd_q;
    assign bus.ADDR    = addr_q;
    assign bus.WR_GNT  = wr_gnt_q;
    assign bus.RD_GNT  = rd_gnt_q;
    assign bus.WR_DONE = wr_done_q;
    assign bus.RD_DONE = rd_done_q;
    assign bus.ACK_ERR = ack_err_q;
    assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_cmd_arbiter
//
// Directed bench for sdram_cmd_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge, so every observation reflects the
// registers loaded by the rising edge just before it. All expected values
// are constants worked out by hand from the intended cycle timing.
// ---------------------------------------------------------------------------
module tb_sdram_cmd_arbiter;

    localparam int ASIZE       = 22;
    localparam int DATA_CYC    = 12;
    localparam int ACK_TIMEOUT = 64;

    logic CLK;
    logic RESET_N;
    int   vec_count;
    int   miscompare_count;

    sdram_cmd_arbiter_if #(.ASIZE(ASIZE)) bus ();

    sdram_cmd_arbiter #(
        .ASIZE      (ASIZE),
        .DATA_CYC   (DATA_CYC),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    // 100 MHz free-running clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case a bounded wait is ever mis-coded.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish before 100000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports it if observed and expected differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives every requester and command-port input in one go.
    task automatic applyStimulus(input logic wr_req, input logic [ASIZE-1:0] wr_addr,
                                 input logic rd_req, input logic [ASIZE-1:0] rd_addr,
                                 input logic cmd_ack);
        bus.WR_REQ  = wr_req;
        bus.WR_ADDR = wr_addr;
        bus.RD_REQ  = rd_req;
        bus.RD_ADDR = rd_addr;
        bus.CMD_ACK = cmd_ack;
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Every output must sit at its reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_cmd"},     32'(bus.CMD),     32'h0);
        checkOutput({tag, "_addr"},    32'(bus.ADDR),    32'h0);
        checkOutput({tag, "_wr_gnt"},  32'(bus.WR_GNT),  32'h0);
        checkOutput({tag, "_rd_gnt"},  32'(bus.RD_GNT),  32'h0);
        checkOutput({tag, "_wr_done"}, 32'(bus.WR_DONE), 32'h0);
        checkOutput({tag, "_rd_done"}, 32'(bus.RD_DONE), 32'h0);
        checkOutput({tag, "_ack_err"}, 32'(bus.ACK_ERR), 32'h0);
        checkOutput({tag, "_busy"},    32'(bus.BUSY),    32'h1);
    endtask

    // Steps until either grant is seen, at most max_cycles times. A missing
    // grant is itself reported as a miscompare.
    task automatic waitGrant(input string tag, input int max_cycles,
                             output logic got_wr, output logic got_rd,
                             output int cycles);
        logic seen;
        seen   = 1'b0;
        got_wr = 1'b0;
        got_rd = 1'b0;
        cycles = 0;
        for (int i = 1; i <= max_cycles && !seen; i++) begin
            step();
            if (bus.WR_GNT || bus.RD_GNT) begin
                seen   = 1'b1;
                got_wr = bus.WR_GNT;
                got_rd = bus.RD_GNT;
                cycles = i;
            end
        end
        checkOutput({tag, "_grant_seen"}, 32'(seen), 32'h1);
    endtask

    initial begin
        logic gw, gr, bad;
        int   cyc, done_at, done_pulses, err_at, n;

        vec_count        = 0;
        miscompare_count = 0;

        // ---------------- reset values ----------------
        RESET_N       = 1'b0;
        bus.INIT_DONE = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        repeat (3) step();
        checkResetState("reset");
        RESET_N = 1'b1;

        // ---------------- init hold ----------------
        applyStimulus(1'b1, 22'h12345, 1'b0, '0, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (bus.WR_GNT || bus.RD_GNT || bus.CMD != 2'b00 || !bus.BUSY) bad = 1'b1;
        end
        checkOutput("init_hold_quiet", 32'(bad), 32'h0);

        bus.INIT_DONE = 1'b1;
        step();
        checkOutput("init_arb_wr_gnt", 32'(bus.WR_GNT), 32'h0);
        checkOutput("init_arb_busy",   32'(bus.BUSY),   32'h0);
        step();
        checkOutput("init_wr_gnt", 32'(bus.WR_GNT), 32'h1);
        checkOutput("init_cmd",    32'(bus.CMD),    32'h2);
        checkOutput("init_addr",   32'(bus.ADDR),   32'h12345);
        checkOutput("init_busy",   32'(bus.BUSY),   32'h1);

        // ---------------- single write, ACK in third CMD cycle ----------------
        applyStimulus(1'b0, 22'h12345, 1'b0, '0, 1'b0);
        step();
        checkOutput("wr_gnt_one_cycle", 32'(bus.WR_GNT), 32'h0);
        checkOutput("wr_cmd_hold2",     32'(bus.CMD),    32'h2);
        checkOutput("wr_addr_hold2",    32'(bus.ADDR),   32'h12345);
        step();
        checkOutput("wr_cmd_hold3", 32'(bus.CMD), 32'h2);
        applyStimulus(1'b0, 22'h12345, 1'b0, '0, 1'b1);
        done_at     = 0;
        done_pulses = 0;
        bad         = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 1) begin
                applyStimulus(1'b0, 22'h12345, 1'b0, '0, 1'b0);
                checkOutput("wr_cmd_after_ack", 32'(bus.CMD), 32'h0);
                checkOutput("wr_busy_in_data",  32'(bus.BUSY), 32'h1);
            end
            if (bus.WR_DONE) begin
                done_pulses++;
                if (done_at == 0) done_at = i;
            end
            if (bus.RD_DONE || bus.ACK_ERR) bad = 1'b1;
            if (i == 13) checkOutput("wr_busy_after_done", 32'(bus.BUSY), 32'h0);
        end
        checkOutput("wr_done_latency", 32'(done_at),     32'(DATA_CYC));
        checkOutput("wr_done_pulses",  32'(done_pulses), 32'h1);
        checkOutput("wr_no_stray",     32'(bad),         32'h0);

        // ---------------- stray ACK while idle in ARB ----------------
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("stray_arb_busy", 32'(bus.BUSY), 32'h0);
        checkOutput("stray_arb_cmd",  32'(bus.CMD),  32'h0);
        step();
        checkOutput("stray_arb_busy2", 32'(bus.BUSY), 32'h0);

        // ---------------- read, ACK at once, stray ACK in DATA ----------------
        applyStimulus(1'b0, '0, 1'b1, 22'h0ABCD, 1'b0);
        step();
        checkOutput("rd_gnt",    32'(bus.RD_GNT), 32'h1);
        checkOutput("rd_wr_gnt", 32'(bus.WR_GNT), 32'h0);
        checkOutput("rd_cmd",    32'(bus.CMD),    32'h1);
        checkOutput("rd_addr",   32'(bus.ADDR),   32'h0ABCD);
        applyStimulus(1'b0, '0, 1'b0, 22'h0ABCD, 1'b1);
        done_at     = 0;
        done_pulses = 0;
        bad         = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step();
            applyStimulus(1'b0, '0, 1'b0, 22'h0ABCD, (i == 4));
            if (bus.RD_DONE) begin
                done_pulses++;
                if (done_at == 0) done_at = i;
            end
            if (bus.WR_DONE || bus.CMD != 2'b00 || bus.RD_GNT) bad = 1'b1;
            if (i == 13) checkOutput("rd_busy_after_done", 32'(bus.BUSY), 32'h0);
        end
        checkOutput("rd_done_latency", 32'(done_at),     32'(DATA_CYC));
        checkOutput("rd_done_pulses",  32'(done_pulses), 32'h1);
        checkOutput("rd_stray_quiet",  32'(bad),         32'h0);

        // ---------------- round robin, both requests held ----------------
        applyStimulus(1'b1, 22'h00AAA, 1'b1, 22'h00555, 1'b0);
        for (int g = 0; g < 4; g++) begin
            waitGrant("rr", 40, gw, gr, cyc);
            checkOutput("rr_wr_gnt", 32'(gw), 32'((g % 2) == 0));
            checkOutput("rr_rd_gnt", 32'(gr), 32'((g % 2) == 1));
            checkOutput("rr_cmd",    32'(bus.CMD),  ((g % 2) == 0) ? 32'h2 : 32'h1);
            checkOutput("rr_addr",   32'(bus.ADDR), ((g % 2) == 0) ? 32'h00AAA : 32'h00555);
            if (g > 0) checkOutput("rr_spacing", 32'(cyc + 1), 32'(DATA_CYC + 2));
            bus.CMD_ACK = 1'b1;
            step();
            if (g == 3) applyStimulus(1'b1, 22'h3FFFFF, 1'b0, 22'h00555, 1'b0);
            else        bus.CMD_ACK = 1'b0;
        end

        // ---------------- ACK timeout with a read pending ----------------
        waitGrant("tmo", 40, gw, gr, cyc);
        checkOutput("tmo_wr_gnt", 32'(gw),       32'h1);
        checkOutput("tmo_addr",   32'(bus.ADDR), 32'h3FFFFF);
        applyStimulus(1'b0, 22'h3FFFFF, 1'b1, 22'h000001, 1'b0);
        err_at = 0;
        bad    = 1'b0;
        n      = 0;
        while (err_at == 0 && n < 80) begin
            step();
            n++;
            if (bus.ACK_ERR) err_at = n;
            else if (bus.CMD != 2'b10) bad = 1'b1;
            if (bus.WR_DONE || bus.RD_DONE || bus.RD_GNT) bad = 1'b1;
        end
        checkOutput("tmo_latency",   32'(err_at),  32'(ACK_TIMEOUT));
        checkOutput("tmo_cmd_held",  32'(bad),     32'h0);
        checkOutput("tmo_cmd_nop",   32'(bus.CMD), 32'h0);
        step();
        checkOutput("tmo_err_pulse", 32'(bus.ACK_ERR), 32'h0);
        checkOutput("tmo_rd_gnt",    32'(bus.RD_GNT),  32'h1);
        checkOutput("tmo_rd_cmd",    32'(bus.CMD),     32'h1);
        checkOutput("tmo_rd_addr",   32'(bus.ADDR),    32'h000001);

        // ---------------- reset in the middle of the DATA window ----------------
        applyStimulus(1'b0, '0, 1'b0, 22'h000001, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0, 22'h000001, 1'b0);
        repeat (4) step();
        RESET_N       = 1'b0;
        bus.INIT_DONE = 1'b0;
        #1;
        checkResetState("rst_mid");
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.RD_DONE || bus.WR_DONE) bad = 1'b1;
        end
        checkOutput("rst_no_done", 32'(bad), 32'h0);
        RESET_N = 1'b1;
        applyStimulus(1'b1, 22'h2AAAA, 1'b1, 22'h15555, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.WR_GNT || bus.RD_GNT || !bus.BUSY) bad = 1'b1;
        end
        checkOutput("rst_wait_init", 32'(bad), 32'h0);
        bus.INIT_DONE = 1'b1;
        step();
        checkOutput("rst_arb_gnt", 32'(bus.WR_GNT | bus.RD_GNT), 32'h0);
        step();
        checkOutput("rst_tie_wr_gnt", 32'(bus.WR_GNT), 32'h1);
        checkOutput("rst_tie_rd_gnt", 32'(bus.RD_GNT), 32'h0);
        checkOutput("rst_tie_cmd",    32'(bus.CMD),    32'h2);
        checkOutput("rst_tie_addr",   32'(bus.ADDR),   32'h2AAAA);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
